// File: rtl/bitrev_reorder_ctrl_if.sv
// Stream bundle for the bit-reverse reorder buffer: FFT-side input stream and
// consumer-side output stream with per-sample bin index and end-of-frame flag.
interface bitrev_reorder_ctrl_if #(
  parameter int N = 3,
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_idx;
  logic         out_last;
  logic         out_ready;

  // Environment view: produces FFT samples and consumes reordered bins.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // Reorder block view.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/bitrev_reorder_ctrl.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order, are stored in
// arrival order and read back at bit-reversed addresses to give natural-order bins.
module bitrev_reorder_ctrl #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitrev_reorder_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] CNT_MAX = '1;

  logic [W-1:0] mem [2][DEPTH];

  logic         wr_bank;
  logic [N-1:0] wr_cnt;
  logic         rd_bank;
  logic [N-1:0] rd_cnt;
  logic [1:0]   bank_full;
  logic [1:0]   bank_full_d;

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [N-1:0] out_idx_q;
  logic         out_last_q;

  logic         in_ready;
  logic         wr_fire;
  logic         wr_last;
  logic         rd_load;
  logic         rd_last;

  function automatic logic [N-1:0] rev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  // Write side may only use a bank the read side has released.
  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = bus.in_valid && in_ready;
  assign wr_last  = wr_fire && (wr_cnt == CNT_MAX);

  // Output register reloads when empty or when its current word is taken.
  assign rd_load  = bank_full[rd_bank] && (!out_valid_q || bus.out_ready);
  assign rd_last  = rd_load && (rd_cnt == CNT_MAX);

  // A set (write side) and a clear (read side) always target different banks:
  // the write bank is not full, the read bank is.
  always_comb begin
    // NOTE: default first so every path assigns bank_full_d and no latch is inferred.
    bank_full_d = bank_full;
    if (wr_last) bank_full_d[wr_bank] = 1'b1;
    if (rd_last) bank_full_d[rd_bank] = 1'b0;
  end

  // NOTE: sample storage is deliberately not reset; control state alone decides
  // which words are meaningful, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update order-independent.
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_bank     <= 1'b0;
      rd_cnt      <= '0;
      bank_full   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      bank_full <= bank_full_d;

      if (wr_fire) begin
        wr_cnt <= wr_cnt + N'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end

      if (rd_load) begin
        out_data_q  <= mem[rd_bank][rev(rd_cnt)];
        out_idx_q   <= rd_cnt;
        out_last_q  <= (rd_cnt == CNT_MAX);
        out_valid_q <= 1'b1;
        rd_cnt      <= rd_cnt + N'(1);
        if (rd_last) rd_bank <= ~rd_bank;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Self-checking bench for bitrev_reorder_ctrl: frame-level reference model with
// an expected-output queue, directed scenarios and randomized handshakes.
module tb_bitrev_reorder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitrev_reorder_ctrl_if #(.N(3), .W(16)) bus3 ();
  bitrev_reorder_ctrl_if #(.N(4), .W(8))  bus4 ();

  bitrev_reorder_ctrl #(.N(3), .W(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  bitrev_reorder_ctrl #(.N(4), .W(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_fire = 0;
  int first_fire_cyc = -1;
  int last_fire_cyc = -1;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];

  function automatic int rev_idx(input int i, input int n);
    int r = 0;
    for (int b = 0; b < n; b++)
      if (((i >> b) & 1) == 1) r = r + (1 << (n - 1 - b));
    return r;
  endfunction

  // A completed frame yields bin k = sample that arrived at position rev(k).
  task automatic model_accept(input logic [15:0] d);
    exp_t e;
    frame_q.push_back(d);
    if (frame_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        e.data = frame_q[rev_idx(k, 3)];
        e.idx  = 3'(k);
        e.last = (k == 7);
        exp_q.push_back(e);
      end
      frame_q.delete();
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] id, input logic ordy, output logic acc);
    logic        fire;
    logic        hold;
    logic [15:0] pd;
    logic [2:0]  pi;
    logic        pl;
    exp_t        e;
    bus3.in_valid  = iv;
    bus3.in_data   = id;
    bus3.out_ready = ordy;
    acc  = iv && bus3.in_ready;
    fire = bus3.out_valid && ordy;
    hold = bus3.out_valid && !ordy;
    pd = bus3.out_data;
    pi = bus3.out_idx;
    pl = bus3.out_last;
    if (rst_n && fire) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d got data=%0d idx=%0d, expected no output", cyc, pd, pi);
      end else begin
        e = exp_q.pop_front();
        if ({pd, pi, pl} !== {e.data, e.idx, e.last}) begin
          failures++;
          $display("FAIL output cyc=%0d got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d last=%0b",
                   cyc, pd, pi, pl, e.data, e.idx, e.last);
        end
      end
      n_fire++;
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      acc = 1'b0;
    end else begin
      if (acc) model_accept(id);
      if (hold) begin
        checks++;
        if ({bus3.out_valid, bus3.out_data, bus3.out_idx, bus3.out_last} !== {1'b1, pd, pi, pl}) begin
          failures++;
          $display("FAIL hold_stable cyc=%0d got v=%0b data=%0d idx=%0d last=%0b, expected v=1 data=%0d idx=%0d last=%0b",
                   cyc, bus3.out_valid, bus3.out_data, bus3.out_idx, bus3.out_last, pd, pi, pl);
        end
      end
    end
  endtask

  task automatic do_reset();
    logic acc;
    rst_n = 1'b0;
    step(1'b0, 16'd0, 1'b0, acc);
    step(1'b0, 16'd0, 1'b0, acc);
    rst_n = 1'b1;
    n_fire = 0;
    first_fire_cyc = -1;
    last_fire_cyc = -1;
  endtask

  task automatic drain(input int max_cycles, input bit rand_ready, input string name);
    logic acc;
    int   n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step(1'b0, 16'd0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_timeout remaining=%0d, expected 0 within %0d cycles", name, exp_q.size(), max_cycles);
    end
    step(1'b0, 16'd0, 1'b1, acc);
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after_drain out_valid=%0b, expected 0", name, bus3.out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus3.out_valid, bus3.out_data, bus3.out_idx, bus3.out_last, bus3.in_ready} !== {1'b0, 16'd0, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got v=%0b data=%0d idx=%0d last=%0b in_ready=%0b, expected 0/0/0/0/1",
               bus3.out_valid, bus3.out_data, bus3.out_idx, bus3.out_last, bus3.in_ready);
    end
  endtask

  task automatic test_single_frame();
    logic acc;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b1, acc);
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early out_valid=%0b after last write edge, expected 0", bus3.out_valid);
    end
    step(1'b0, 16'd0, 1'b1, acc);
    checks++;
    if ({bus3.out_valid, bus3.out_idx, bus3.out_data} !== {1'b1, 3'd0, 16'd0}) begin
      failures++;
      $display("FAIL latency_bin0 got v=%0b idx=%0d data=%0d, expected v=1 idx=0 data=0",
               bus3.out_valid, bus3.out_idx, bus3.out_data);
    end
    drain(50, 1'b0, "single_frame");
  endtask

  task automatic test_back_to_back();
    logic acc;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (bus3.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready cyc=%0d got %0b, expected 1", cyc, bus3.in_ready);
      end
      step(1'b1, 16'(i), 1'b1, acc);
    end
    drain(50, 1'b0, "b2b");
    checks++;
    if (n_fire != 24 || (last_fire_cyc - first_fire_cyc) != 23) begin
      failures++;
      $display("FAIL b2b_no_bubbles got fires=%0d span=%0d, expected fires=24 span=23",
               n_fire, last_fire_cyc - first_fire_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'(i), 1'b0, acc);
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept i=%0d got accepted=%0b, expected 1", i, acc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus3.in_ready, bus3.out_valid, bus3.out_data, bus3.out_idx} !== {1'b0, 1'b1, 16'd0, 3'd0}) begin
        failures++;
        $display("FAIL bp_full_hold got in_ready=%0b v=%0b data=%0d idx=%0d, expected 0/1/0/0",
                 bus3.in_ready, bus3.out_valid, bus3.out_data, bus3.out_idx);
      end
      step(1'b1, 16'(16 + i), 1'b0, acc);
    end
    for (int j = 0; j < 7; j++) begin
      step(1'b0, 16'd0, 1'b1, acc);
      checks++;
      if (bus3.in_ready !== (j == 6)) begin
        failures++;
        $display("FAIL bp_in_ready_release j=%0d got %0b, expected %0b", j, bus3.in_ready, (j == 6));
      end
    end
    drain(50, 1'b0, "backpressure");
  endtask

  task automatic test_random();
    logic acc;
    int   n_acc = 0;
    int   guard = 0;
    do_reset();
    while (n_acc < 80 && guard < 4000) begin
      step(1'($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom_range(0, 1)), acc);
      if (acc) n_acc++;
      guard++;
    end
    checks++;
    if (n_acc != 80) begin
      failures++;
      $display("FAIL random_accept_timeout got %0d accepts, expected 80", n_acc);
    end
    drain(2000, 1'b1, "random");
  endtask

  task automatic test_reset_mid();
    logic acc;
    do_reset();
    for (int i = 0; i < 13; i++) step(1'b1, 16'(i), 1'b1, acc);
    rst_n = 1'b0;
    step(1'b1, 16'd99, 1'b1, acc);
    rst_n = 1'b1;
    checks++;
    if ({bus3.out_valid, bus3.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_state got v=%0b in_ready=%0b, expected v=0 in_ready=1", bus3.out_valid, bus3.in_ready);
    end
    n_fire = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(100 + i), 1'b1, acc);
    drain(50, 1'b0, "reset_mid");
    checks++;
    if (n_fire != 8) begin
      failures++;
      $display("FAIL reset_mid_count got %0d outputs, expected 8", n_fire);
    end
  endtask

  task automatic test_n4();
    int exp4[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int got = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      bus4.in_valid  = (c < 16);
      bus4.in_data   = 8'(c);
      bus4.out_ready = 1'b1;
      if (bus4.out_valid) begin
        checks++;
        if ({bus4.out_data, bus4.out_idx, bus4.out_last} !== {8'(exp4[got]), 4'(got), (got == 15)}) begin
          failures++;
          $display("FAIL n4_output k=%0d got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d last=%0b",
                   got, bus4.out_data, bus4.out_idx, bus4.out_last, exp4[got], got, (got == 15));
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    bus4.in_valid = 1'b0;
    checks++;
    if (got != 16) begin
      failures++;
      $display("FAIL n4_count got %0d outputs, expected 16", got);
    end
  endtask

  initial begin
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    do_reset();
    test_n4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
